time_set_controller: RTL and testbench

//  Sequences the calendar/clock counter chain through a manual time-set procedure.
//  In RUN it enables counting. A mode press freezes the chain and captures the live

---
 rtl/time_set_controller.sv | 169 ++++++++++++++++
 tb/tb_time_set_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// time_set_controller: freezes the clock/calendar chain, edits shadow BCD time fields, commits them with a load strobe
// Ports:
//   clk, reset (async, active-low)
//   btn_mode/btn_next/btn_inc : debounced synchronous button levels
//   leap                      : leap-year flag for the edited year
//   cur_hour/min/day/month/year : live BCD time from the counter chain
//   run_en, load              : counter chain enable and one-cycle commit strobe
//   set_hour/min/day/month/year : shadow BCD values presented to the chain
//   field_sel, blink_on       : selected edit field and its blank phase
module time_set_controller #(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        leap,
  input  logic [5:0]  cur_hour,
  input  logic [6:0]  cur_min,
  input  logic [5:0]  cur_day,
  input  logic [4:0]  cur_month,
  input  logic [15:0] cur_year,
  output logic        run_en,
  output logic        load,
  output logic [5:0]  set_hour,
  output logic [6:0]  set_min,
  output logic [5:0]  set_day,
  output logic [4:0]  set_month,
  output logic [15:0] set_year,
  output logic [2:0]  field_sel,
  output logic        blink_on
);
  typedef enum logic [2:0] {RUN, CAPTURE, E_HOUR, E_MIN, E_DAY, E_MONTH, E_YEAR, COMMIT} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  state_t state, state_nx;
  logic mode_q, next_q, inc_q;
  logic mode_e, next_e, inc_e;
  logic raw_m, raw_n, raw_i;
  logic edit, any_e, timeout;
  logic [TW-1:0] tmr;
  logic [BW-1:0] bcnt;
  logic [5:0] max_day;

  function automatic logic [5:0] inc_hour(input logic [5:0] h);
    return h == 6'h23 ? 6'h00 : h[3:0] == 4'd9 ? {h[5:4] + 2'd1, 4'd0} : {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] inc_min(input logic [6:0] m);
    return m[3:0] != 4'd9 ? {m[6:4], m[3:0] + 4'd1} : m[6:4] == 3'd5 ? 7'h00 : {m[6:4] + 3'd1, 4'd0};
  endfunction

  // Anything at or beyond the month's last day wraps to 01.
  function automatic logic [5:0] inc_day(input logic [5:0] d, input logic [5:0] md);
    return d >= md ? 6'h01 : d[3:0] == 4'd9 ? {d[5:4] + 2'd1, 4'd0} : {d[5:4], d[3:0] + 4'd1};
  endfunction

  function automatic logic [4:0] inc_month(input logic [4:0] m);
    return m >= 5'h12 ? 5'h01 : m[3:0] == 4'd9 ? 5'h10 : {m[4], m[3:0] + 4'd1};
  endfunction

  // Ripple carry through four BCD digits; 9999 rolls to 0000.
  function automatic logic [15:0] inc_year(input logic [15:0] y);
    logic [15:0] r;
    logic c;
    r = y;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
        else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign raw_m = btn_mode & ~mode_q;
  assign raw_n = btn_next & ~next_q;
  assign raw_i = btn_inc & ~inc_q;
  assign edit = state inside {E_HOUR, E_MIN, E_DAY, E_MONTH, E_YEAR};
  assign any_e = mode_e | next_e | inc_e;
  assign timeout = edit && !any_e && tmr == TW'(TIMEOUT_CYC);
  assign max_day = set_month == 5'h02 ? (leap ? 6'h29 : 6'h28) :
                   set_month inside {5'h04, 5'h06, 5'h09, 5'h11} ? 6'h30 : 6'h31;

  // Registered edges with same-cycle priority mode > next > inc already resolved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {mode_q, next_q, inc_q} <= '0;
      {mode_e, next_e, inc_e} <= '0;
    end else begin
      {mode_q, next_q, inc_q} <= {btn_mode, btn_next, btn_inc};
      mode_e <= raw_m;
      next_e <= raw_n & ~raw_m;
      inc_e  <= raw_i & ~raw_m & ~raw_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = mode_e ? CAPTURE : RUN;
      CAPTURE: state_nx = E_HOUR;
      COMMIT:  state_nx = RUN;
      default: state_nx = mode_e ? COMMIT : timeout ? RUN :
                          next_e ? (state == E_YEAR ? E_HOUR : state_t'(3'(state) + 3'd1)) : state;
    endcase
  end

  // Edit states are encoded consecutively from E_HOUR, so the field number is state-1.
  always_comb begin
    run_en = state == RUN;
    load = state == COMMIT;
    field_sel = edit ? 3'(state) - 3'd1 : 3'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmr <= '0;
    else if (!edit || any_e) tmr <= '0;
    else if (tmr != TW'(TIMEOUT_CYC)) tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt <= '0;
      blink_on <= 1'b0;
    end else if (!edit || any_e) begin
      bcnt <= '0;
      blink_on <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt <= '0;
      blink_on <= ~blink_on;
    end else bcnt <= bcnt + 1'b1;
  end

  // Day clamp happens on the commit transition so set_day is already valid while load is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_hour <= 6'h00;
      set_min <= 7'h00;
      set_day <= 6'h01;
      set_month <= 5'h01;
      set_year <= 16'h0000;
    end else if (state == CAPTURE) begin
      set_hour <= cur_hour;
      set_min <= cur_min;
      set_day <= cur_day;
      set_month <= cur_month;
      set_year <= cur_year;
    end else if (edit && mode_e) set_day <= set_day > max_day ? max_day : set_day;
    else if (edit && inc_e) begin
      if (state == E_HOUR) set_hour <= inc_hour(set_hour);
      if (state == E_MIN) set_min <= inc_min(set_min);
      if (state == E_DAY) set_day <= inc_day(set_day, max_day);
      if (state == E_MONTH) set_month <= inc_month(set_month);
      if (state == E_YEAR) set_year <= inc_year(set_year);
    end
  end
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed checks of capture, BCD wraps, leap/clamp, timeout, priority and reset
module tb_time_set_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, leap = 1'b0;
  logic [5:0] cur_hour = 6'h00;
  logic [6:0] cur_min = 7'h00;
  logic [5:0] cur_day = 6'h01;
  logic [4:0] cur_month = 5'h01;
  logic [15:0] cur_year = 16'h0000;
  logic run_en, load, blink_on;
  logic [5:0] set_hour, set_day;
  logic [6:0] set_min;
  logic [4:0] set_month;
  logic [15:0] set_year;
  logic [2:0] field_sel;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_set_controller #(.BLINK_DIV(4), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .leap(leap), .cur_hour(cur_hour), .cur_min(cur_min), .cur_day(cur_day),
    .cur_month(cur_month), .cur_year(cur_year), .run_en(run_en), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_day(set_day), .set_month(set_month),
    .set_year(set_year), .field_sel(field_sel), .blink_on(blink_on)
  );

  task do_reset;
    reset = 1'b0;
    {btn_mode, btn_next, btn_inc} = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task press(input logic m, input logic n, input logic i);
    @(negedge clk);
    {btn_mode, btn_next, btn_inc} = {m, n, i};
    @(negedge clk);
    {btn_mode, btn_next, btn_inc} = 3'b000;
    @(negedge clk);
  endtask

  task enter(input logic [5:0] h, input logic [6:0] mi, input logic [5:0] d, input logic [4:0] mo, input logic [15:0] y);
    {cur_hour, cur_min, cur_day, cur_month, cur_year} = {h, mi, d, mo, y};
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task nexts(input int k);
    repeat (k) press(1'b0, 1'b1, 1'b0);
  endtask

  task test_reset;
    do_reset;
    checks++;
    if ({run_en, load, field_sel, blink_on} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100000", {run_en, load, field_sel, blink_on});
    end
    checks++;
    if ({set_hour, set_min, set_day, set_month, set_year} !== {6'h00, 7'h00, 6'h01, 5'h01, 16'h0000}) begin
      errors++;
      $display("FAIL reset_shadow got %h:%h %h/%h %h", set_hour, set_min, set_day, set_month, set_year);
    end
  endtask

  task test_capture;
    do_reset;
    {cur_hour, cur_min, cur_day, cur_month, cur_year} = {6'h23, 7'h59, 6'h31, 5'h12, 16'h1999};
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (run_en !== 1'b0) begin
      errors++;
      $display("FAIL capture_run_en got %b exp 0", run_en);
    end
    @(negedge clk);
    checks++;
    if (field_sel !== 3'd1) begin
      errors++;
      $display("FAIL capture_field got %0d exp 1", field_sel);
    end
    checks++;
    if ({set_hour, set_min, set_day, set_month, set_year} !== {6'h23, 7'h59, 6'h31, 5'h12, 16'h1999}) begin
      errors++;
      $display("FAIL capture_shadow got %h:%h %h/%h %h", set_hour, set_min, set_day, set_month, set_year);
    end
  endtask

  task test_wraps;
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_hour !== 6'h00) begin
      errors++;
      $display("FAIL hour_wrap got %h exp 00", set_hour);
    end
    nexts(1);
    checks++;
    if (field_sel !== 3'd2) begin
      errors++;
      $display("FAIL field_min got %0d exp 2", field_sel);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_min !== 7'h00) begin
      errors++;
      $display("FAIL min_wrap got %h exp 00", set_min);
    end
    nexts(3);
    checks++;
    if (field_sel !== 3'd5) begin
      errors++;
      $display("FAIL field_year got %0d exp 5", field_sel);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_year !== 16'h2000) begin
      errors++;
      $display("FAIL year_carry got %h exp 2000", set_year);
    end
    nexts(1);
    checks++;
    if (field_sel !== 3'd1) begin
      errors++;
      $display("FAIL field_wrap got %0d exp 1", field_sel);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL commit_load got %b exp 1", load);
    end
    @(negedge clk);
    enter(6'h01, 7'h02, 6'h03, 5'h04, 16'h9999);
    nexts(4);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_year !== 16'h0000) begin
      errors++;
      $display("FAIL year_wrap got %h exp 0000", set_year);
    end
  endtask

  task test_leap;
    do_reset;
    leap = 1'b1;
    enter(6'h00, 7'h00, 6'h28, 5'h02, 16'h2024);
    nexts(2);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_day !== 6'h29) begin
      errors++;
      $display("FAIL leap_29 got %h exp 29", set_day);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_day !== 6'h01) begin
      errors++;
      $display("FAIL leap_wrap got %h exp 01", set_day);
    end
    leap = 1'b0;
    do_reset;
    enter(6'h00, 7'h00, 6'h28, 5'h02, 16'h2023);
    nexts(2);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_day !== 6'h01) begin
      errors++;
      $display("FAIL noleap_wrap got %h exp 01", set_day);
    end
  endtask

  task test_clamp;
    do_reset;
    enter(6'h08, 7'h15, 6'h31, 5'h03, 16'h2021);
    nexts(3);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (set_month !== 5'h04) begin
      errors++;
      $display("FAIL month_inc got %h exp 04", set_month);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if ({load, run_en, set_day} !== {1'b1, 1'b0, 6'h30}) begin
      errors++;
      $display("FAIL clamp_commit got load=%b run=%b day=%h exp load=1 run=0 day=30", load, run_en, set_day);
    end
    @(negedge clk);
    checks++;
    if ({load, run_en} !== 2'b01) begin
      errors++;
      $display("FAIL clamp_after got load=%b run=%b exp load=0 run=1", load, run_en);
    end
  endtask

  task test_timeout;
    logic saw_load;
    saw_load = 1'b0;
    do_reset;
    enter(6'h10, 7'h20, 6'h05, 5'h06, 16'h2020);
    repeat (3) @(negedge clk);
    checks++;
    if (blink_on !== 1'b0) begin
      errors++;
      $display("FAIL blink_early got %b exp 0", blink_on);
    end
    @(negedge clk);
    checks++;
    if (blink_on !== 1'b1) begin
      errors++;
      $display("FAIL blink_toggle got %b exp 1", blink_on);
    end
    repeat (36) begin
      @(negedge clk);
      saw_load |= load;
    end
    checks++;
    if (run_en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got run_en=%b exp 0", run_en);
    end
    repeat (20) begin
      @(negedge clk);
      saw_load |= load;
    end
    checks++;
    if ({run_en, saw_load, field_sel} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL timeout_exit got run=%b load_seen=%b field=%0d exp run=1 load_seen=0 field=0", run_en, saw_load, field_sel);
    end
    checks++;
    if (set_hour !== 6'h10) begin
      errors++;
      $display("FAIL timeout_keep got %h exp 10", set_hour);
    end
  endtask

  task test_hold;
    do_reset;
    enter(6'h05, 7'h00, 6'h01, 5'h01, 16'h2000);
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (5) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    checks++;
    if (set_hour !== 6'h06) begin
      errors++;
      $display("FAIL hold_once got %h exp 06", set_hour);
    end
  endtask

  task test_priority;
    do_reset;
    enter(6'h07, 7'h30, 6'h01, 5'h01, 16'h2000);
    press(1'b0, 1'b1, 1'b1);
    checks++;
    if ({field_sel, set_hour} !== {3'd2, 6'h07}) begin
      errors++;
      $display("FAIL next_over_inc got field=%0d hour=%h exp field=2 hour=07", field_sel, set_hour);
    end
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if ({load, set_min} !== {1'b1, 7'h30}) begin
      errors++;
      $display("FAIL mode_over_inc got load=%b min=%h exp load=1 min=30", load, set_min);
    end
    @(negedge clk);
  endtask

  task test_reset_mid;
    do_reset;
    enter(6'h12, 7'h34, 6'h15, 5'h07, 16'h2010);
    press(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    checks++;
    if ({run_en, load, field_sel, blink_on} !== 6'b100000) begin
      errors++;
      $display("FAIL midreset_ctrl got %b exp 100000", {run_en, load, field_sel, blink_on});
    end
    checks++;
    if ({set_hour, set_min, set_day, set_month, set_year} !== {6'h00, 7'h00, 6'h01, 5'h01, 16'h0000}) begin
      errors++;
      $display("FAIL midreset_shadow got %h:%h %h/%h %h", set_hour, set_min, set_day, set_month, set_year);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({run_en, load} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_after got run=%b load=%b exp run=1 load=0", run_en, load);
    end
  endtask

  initial begin
    test_reset;
    test_capture;
    test_wraps;
    test_leap;
    test_clamp;
    test_timeout;
    test_hold;
    test_priority;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
